// File: rtl/intersection_scheduler_pkg.sv
// Shared encodings for the intersection scheduler: per-approach light codes
// and the phase encoding presented on the phase output.
package intersection_scheduler_pkg;

    // One-hot light code per approach.
    localparam logic [2:0] GRN = 3'b100;
    localparam logic [2:0] YLW = 3'b010;
    localparam logic [2:0] RED = 3'b001;

    // Intersection phase; PH_WALK is reachable only in the pedestrian build.
    typedef enum logic [1:0] {
        PH_GREEN  = 2'b00,
        PH_YELLOW = 2'b01,
        PH_ALLRED = 2'b10,
        PH_WALK   = 2'b11
    } phase_t;

endpackage

// File: rtl/intersection_scheduler_rr_next_picker.sv
// Round-robin picker: first approach with latched demand, searching
// owner+1, owner+2, ... with wrap. found=0 when nothing is pending.
module rr_next_picker #(
    parameter int N  = 4,
    parameter int IW = $clog2(N)
) (
    input  logic [IW-1:0] owner,
    input  logic [N-1:0]  pending,
    output logic [IW-1:0] next,
    output logic          found
);

    // Walk the ring once starting just after the owner; the owner itself is last.
    always_comb begin
        int idx;
        // NOTE: every signal written here gets a default first so no latch is inferred.
        next  = '0;
        found = 1'b0;
        idx   = 0;
        for (int i = 1; i <= N; i++) begin
            idx = (int'(owner) + i) % N;
            if (!found && pending[idx]) begin
                next  = IW'(idx);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/intersection_scheduler.sv
// N-approach intersection scheduler: one green at a time, latched demand,
// round-robin hand-over with minimum green, yellow and all-red clearance.
// Optional pedestrian walk phase is enabled by defining SCHED_PED_EN.
module intersection_scheduler
    import intersection_scheduler_pkg::*;
#(
    parameter int N_APPR    = 4,
    parameter int T_MIN_GRN = 4,
    parameter int T_MAX_GRN = 8,
    parameter int T_YLW     = 2,
    parameter int T_ALLRED  = 1,
    parameter int CNT_W     = 4
`ifdef SCHED_PED_EN
    ,
    parameter int T_WALK    = 3
`endif
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [N_APPR-1:0]           car_present,
`ifdef SCHED_PED_EN
    input  logic                        ped_req,
    output logic                        walk,
`endif
    output logic [3*N_APPR-1:0]         lights,
    output logic [$clog2(N_APPR)-1:0]   owner,
    output logic [1:0]                  phase,
    output logic [N_APPR-1:0]           pending
);

    localparam int OW = $clog2(N_APPR);
    localparam logic [CNT_W-1:0] MIN_LAST  = CNT_W'(T_MIN_GRN - 1);
    localparam logic [CNT_W-1:0] MAX_LAST  = CNT_W'(T_MAX_GRN - 1);
    localparam logic [CNT_W-1:0] YLW_LAST  = CNT_W'(T_YLW - 1);
    localparam logic [CNT_W-1:0] AR_LAST   = CNT_W'(T_ALLRED - 1);
`ifdef SCHED_PED_EN
    localparam logic [CNT_W-1:0] WALK_LAST = CNT_W'(T_WALK - 1);
`endif

    phase_t              state_q, state_d;
    logic [OW-1:0]       owner_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [N_APPR-1:0]   pending_d;
    logic [N_APPR-1:0]   owner_mask, grant_mask, hold_mask;
    logic                yield_req;
    logic                enter_green;
    logic [OW-1:0]       pick_idx;
    logic                pick_found;
`ifdef SCHED_PED_EN
    logic                ped_pending_q, ped_pending_d;
    logic                enter_walk;
`endif

    // Lights seen by every approach for a given phase and owner.
    function automatic logic [3*N_APPR-1:0] light_vec(input phase_t ph, input logic [OW-1:0] own);
        logic [3*N_APPR-1:0] v;
        v = '0;
        for (int i = 0; i < N_APPR; i++) begin
            v[3*i +: 3] = RED;
            if (own == OW'(i)) begin
                if (ph == PH_GREEN)
                    v[3*i +: 3] = GRN;
                else if (ph == PH_YELLOW)
                    v[3*i +: 3] = YLW;
            end
        end
        return v;
    endfunction

    rr_next_picker #(
        .N  (N_APPR),
        .IW (OW)
    ) u_picker (
        .owner   (owner),
        .pending (pending),
        .next    (pick_idx),
        .found   (pick_found)
    );

    assign owner_mask = N_APPR'(1) << owner;
    assign phase      = state_q;

    // Next phase, owner, timer and demand from the current phase and latched demand.
    always_comb begin
        state_d     = state_q;
        owner_d     = owner;
        cnt_d       = cnt_q + 1'b1;
        enter_green = 1'b0;
`ifdef SCHED_PED_EN
        enter_walk  = 1'b0;
        yield_req   = (|(pending & ~owner_mask)) | ped_pending_q;
`else
        yield_req   = |(pending & ~owner_mask);
`endif

        case (state_q)
            PH_GREEN: begin
                if (cnt_q == MAX_LAST)
                    cnt_d = cnt_q;
                if (yield_req && cnt_q >= MIN_LAST) begin
                    state_d = PH_YELLOW;
                    cnt_d   = '0;
                end
            end
            PH_YELLOW: begin
                if (cnt_q == YLW_LAST) begin
                    state_d = PH_ALLRED;
                    cnt_d   = '0;
                end
            end
            PH_ALLRED: begin
                if (cnt_q == AR_LAST) begin
`ifdef SCHED_PED_EN
                    if (ped_pending_q) begin
                        state_d    = PH_WALK;
                        cnt_d      = '0;
                        enter_walk = 1'b1;
                    end else begin
                        enter_green = 1'b1;
                    end
`else
                    enter_green = 1'b1;
`endif
                end
            end
`ifdef SCHED_PED_EN
            PH_WALK: begin
                if (cnt_q == WALK_LAST)
                    enter_green = 1'b1;
            end
`endif
            default: begin
                state_d = PH_GREEN;
                cnt_d   = '0;
            end
        endcase

        // Hand-over: round-robin winner, or home road when nobody is waiting.
        if (enter_green) begin
            state_d = PH_GREEN;
            cnt_d   = '0;
            owner_d = pick_found ? pick_idx : '0;
        end

        // Granting clears demand; a car arriving on the owner during its
        // yellow/all-red is kept so it can be served again later.
        grant_mask = enter_green ? (N_APPR'(1) << owner_d) : '0;
        hold_mask  = (state_q == PH_YELLOW || state_q == PH_ALLRED) ? owner_mask : '0;
        pending_d  = (pending & ~grant_mask) | (car_present & (~grant_mask | hold_mask));

`ifdef SCHED_PED_EN
        ped_pending_d = enter_walk ? 1'b0 : (ped_pending_q | ped_req);
`endif
    end

    // State, timer, demand and light registers; reset discards any running phase.
    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q       <= PH_GREEN;
            owner         <= '0;
            cnt_q         <= '0;
            pending       <= '0;
            lights        <= light_vec(PH_GREEN, '0);
`ifdef SCHED_PED_EN
            ped_pending_q <= 1'b0;
            walk          <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state_q       <= state_d;
            owner         <= owner_d;
            cnt_q         <= cnt_d;
            pending       <= pending_d;
            lights        <= light_vec(state_d, owner_d);
`ifdef SCHED_PED_EN
            ped_pending_q <= ped_pending_d;
            walk          <= (state_d == PH_WALK);
`endif
        end
    end

endmodule

// File: tb/tb_intersection_scheduler.sv
// Self-checking bench for intersection_scheduler: directed scenarios plus
// random traffic, compared every cycle against a cycle-level reference model.
// Pedestrian scenario runs only when SCHED_PED_EN is defined.
module tb_intersection_scheduler;

    localparam int N         = 4;
    localparam int T_MIN_GRN = 4;
    localparam int T_MAX_GRN = 8;
    localparam int T_YLW     = 2;
    localparam int T_ALLRED  = 1;
    localparam int T_WALK    = 3;

    logic               clk = 1'b0;
    logic               rst;
    logic [N-1:0]       car_present;
    logic               ped_req;
    logic               walk;
    logic [3*N-1:0]     lights;
    logic [1:0]         owner;
    logic [1:0]         phase;
    logic [N-1:0]       pending;

    int checks = 0;
    int errors = 0;

    // Reference model: phase as 0..3, age = cycles already spent in the phase.
    int         m_phase;
    int         m_owner;
    int         m_age;
    bit [N-1:0] m_pend;
    bit         m_ped;

    intersection_scheduler #(
        .N_APPR    (N),
        .T_MIN_GRN (T_MIN_GRN),
        .T_MAX_GRN (T_MAX_GRN),
        .T_YLW     (T_YLW),
        .T_ALLRED  (T_ALLRED),
        .CNT_W     (4)
`ifdef SCHED_PED_EN
        ,
        .T_WALK    (T_WALK)
`endif
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .car_present (car_present),
`ifdef SCHED_PED_EN
        .ped_req     (ped_req),
        .walk        (walk),
`endif
        .lights      (lights),
        .owner       (owner),
        .phase       (phase),
        .pending     (pending)
    );

`ifndef SCHED_PED_EN
    assign walk = 1'b0;
`endif

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_phase = 0;
        m_owner = 0;
        m_age   = 0;
        m_pend  = '0;
        m_ped   = 1'b0;
    endtask

    task automatic model_step(input bit [N-1:0] car, input bit ped);
        int nphase;
        int nowner;
        bit others;
        bit to_green;
        bit to_walk;
        nphase   = m_phase;
        nowner   = m_owner;
        to_green = 1'b0;
        to_walk  = 1'b0;
        others   = m_ped;
        for (int j = 0; j < N; j++)
            if (j != m_owner && m_pend[j]) others = 1'b1;

        case (m_phase)
            0: if (others && m_age >= T_MIN_GRN - 1) nphase = 1;
            1: if (m_age == T_YLW - 1) nphase = 2;
            2: if (m_age == T_ALLRED - 1) begin
                   if (m_ped) begin nphase = 3; to_walk = 1'b1; end
                   else to_green = 1'b1;
               end
            default: if (m_age == T_WALK - 1) to_green = 1'b1;
        endcase

        if (to_green) begin
            nphase = 0;
            nowner = 0;
            for (int k = 1; k <= N; k++) begin
                if (m_pend[(m_owner + k) % N]) begin
                    nowner = (m_owner + k) % N;
                    break;
                end
            end
        end

        for (int j = 0; j < N; j++) begin
            if (to_green && j == nowner) begin
                if ((m_phase == 1 || m_phase == 2) && j == m_owner)
                    m_pend[j] = car[j];
                else
                    m_pend[j] = 1'b0;
            end else begin
                m_pend[j] = m_pend[j] | car[j];
            end
        end
        m_ped = to_walk ? 1'b0 : (m_ped | ped);

        m_age   = (nphase != m_phase) ? 0 : m_age + 1;
        m_phase = nphase;
        m_owner = nowner;
    endtask

    task automatic compare_all();
        logic [3*N-1:0] exp_l;
        logic [2:0]     code;
        int             nonred;
        exp_l  = '0;
        nonred = 0;
        for (int i = 0; i < N; i++) begin
            code = 3'b001;
            if (i == m_owner && m_phase == 0) code = 3'b100;
            else if (i == m_owner && m_phase == 1) code = 3'b010;
            exp_l[3*i +: 3] = code;
            if (lights[3*i +: 3] != 3'b001) nonred++;
        end
        check("lights", 32'(lights), 32'(exp_l));
        check("owner", 32'(owner), 32'(m_owner));
        check("phase", 32'(phase), 32'(m_phase));
        check("pending", 32'(pending), 32'(m_pend));
        check("single_nonred", 32'(nonred <= 1), 32'd1);
`ifdef SCHED_PED_EN
        check("walk", 32'(walk), 32'(m_phase == 3));
`endif
    endtask

    // Drive inputs for the current cycle, advance one edge, then compare.
    task automatic tick(input logic [N-1:0] car, input logic rst_v, input logic ped_v);
        car_present = car;
        rst         = rst_v;
        ped_req     = ped_v;
        @(posedge clk);
        if (!rst_v) model_reset();
        else model_step(car, ped_v);
        #1;
        compare_all();
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) tick('0, 1'b1, 1'b0);
    endtask

    initial begin
        logic [N-1:0] rcar;
        logic         rrst;
        logic         rped;
        rst         = 1'b0;
        car_present = '0;
        ped_req     = 1'b0;

        // Reset with no traffic: home road green forever.
        tick('0, 1'b0, 1'b0);
        check("rst_lights", 32'(lights), 32'h24C);
        check("rst_pending", 32'(pending), 32'h0);
        idle(50);
        check("idle50_lights", 32'(lights), 32'h24C);
        check("idle50_owner", 32'(owner), 32'h0);
        check("idle50_phase", 32'(phase), 32'h0);

        // Single pulse on approach 2 at cycle 1.
        tick('0, 1'b0, 1'b0);                 // cycle 0
        tick(4'b0000, 1'b1, 1'b0);            // cycle 1
        tick(4'b0100, 1'b1, 1'b0);            // cycle 2
        tick('0, 1'b1, 1'b0);
        check("pulse_c3_grn", 32'(lights), 32'h24C);
        tick('0, 1'b1, 1'b0);
        check("pulse_c4_ylw", 32'(lights), 32'h24A);
        tick('0, 1'b1, 1'b0);
        check("pulse_c5_ylw", 32'(lights), 32'h24A);
        tick('0, 1'b1, 1'b0);
        check("pulse_c6_allred", 32'(lights), 32'h249);
        tick('0, 1'b1, 1'b0);
        check("pulse_c7_grn2", 32'(lights), 32'h309);
        check("pulse_c7_owner", 32'(owner), 32'h2);
        check("pulse_c7_pending", 32'(pending), 32'h0);

        // Owner's own sensor held: stays green; other demand yields 2 cycles later.
        for (int i = 0; i < 20; i++) tick(4'b0100, 1'b1, 1'b0);
        check("hold_stay_grn", 32'(lights), 32'h309);
        tick(4'b0101, 1'b1, 1'b0);
        check("hold_plus1_grn", 32'(lights), 32'h309);
        tick(4'b0100, 1'b1, 1'b0);
        check("hold_plus2_ylw", 32'(lights), 32'h289);
        tick(4'b0100, 1'b1, 1'b0);
        tick(4'b0100, 1'b1, 1'b0);
        check("hold_allred", 32'(lights), 32'h249);
        tick(4'b0100, 1'b1, 1'b0);
        check("hold_next_owner", 32'(owner), 32'h0);

        // Three approaches held from reset: grants 1,2,3 at minimum green.
        tick('0, 1'b0, 1'b0);
        for (int c = 1; c <= 25; c++) begin
            tick(4'b1110, 1'b1, 1'b0);
            case (c)
                7:  check("rr_c7_grn1", 32'(lights), 32'h261);
                10: check("rr_c10_grn1", 32'(lights), 32'h261);
                11: check("rr_c11_ylw1", 32'(lights), 32'h251);
                14: check("rr_c14_grn2", 32'(lights), 32'h309);
                21: check("rr_c21_grn3", 32'(lights), 32'h849);
                default: ;
            endcase
        end

        // Reset during approach 1 yellow discards timer and demand.
        tick('0, 1'b0, 1'b0);
        tick(4'b0010, 1'b1, 1'b0);
        for (int i = 0; i < 6; i++) tick('0, 1'b1, 1'b0);
        check("mrst_c7_grn1", 32'(lights), 32'h261);
        tick(4'b0001, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) tick('0, 1'b1, 1'b0);
        check("mrst_c11_ylw1", 32'(lights), 32'h251);
        tick(4'b1000, 1'b0, 1'b0);
        check("mrst_lights", 32'(lights), 32'h24C);
        check("mrst_pending", 32'(pending), 32'h0);
        check("mrst_owner", 32'(owner), 32'h0);
        check("mrst_phase", 32'(phase), 32'h0);
        tick(4'b0100, 1'b1, 1'b0);
        tick('0, 1'b1, 1'b0);
        tick('0, 1'b1, 1'b0);
        check("mrst_c3_grn", 32'(lights), 32'h24C);
        tick('0, 1'b1, 1'b0);
        check("mrst_c4_ylw", 32'(lights), 32'h24A);

`ifdef SCHED_PED_EN
        // Pedestrian request during home green: walk after clearance, then home again.
        tick('0, 1'b0, 1'b0);
        tick('0, 1'b1, 1'b0);
        tick('0, 1'b1, 1'b1);
        for (int c = 3; c <= 10; c++) begin
            tick('0, 1'b1, 1'b0);
            case (c)
                6:  check("ped_c6_nowalk", 32'(walk), 32'h0);
                7:  begin
                        check("ped_c7_walk", 32'(walk), 32'h1);
                        check("ped_c7_allred", 32'(lights), 32'h249);
                    end
                8:  check("ped_c8_phase", 32'(phase), 32'h3);
                9:  check("ped_c9_walk", 32'(walk), 32'h1);
                10: begin
                        check("ped_c10_nowalk", 32'(walk), 32'h0);
                        check("ped_c10_home", 32'(lights), 32'h24C);
                    end
                default: ;
            endcase
        end
`endif

        // Random traffic with occasional resets.
        tick('0, 1'b0, 1'b0);
        for (int i = 0; i < 600; i++) begin
            rcar = ($urandom_range(0, 5) == 0) ? N'($urandom_range(0, 15)) : '0;
            rrst = ($urandom_range(0, 99) != 0);
`ifdef SCHED_PED_EN
            rped = ($urandom_range(0, 24) == 0);
`else
            rped = 1'b0;
`endif
            tick(rcar, rrst, rped);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/intersection_scheduler.md
Name: intersection_scheduler

Overview:
- Shares one intersection between N_APPR approaches, each with a car sensor and a 3-bit one-hot light.
- Grants green to exactly one approach at a time, using latched demand and round-robin order.
- Enforces minimum green, maximum green, yellow and all-red timing.
- Sits above the per-road stoplight logic and generalises the two-road light to N roads; approach 0 is the home road.

Parameters:
- N_APPR, 4, number of approaches (2..8)
- T_MIN_GRN, 4, minimum green cycles before yielding
- T_MAX_GRN, 8, green cycles after which the owner is forced off if other demand exists
- T_YLW, 2, yellow cycles
- T_ALLRED, 1, all-red clearance cycles
- CNT_W, 4, phase counter width; must hold max(T_MAX_GRN, T_YLW, T_ALLRED)

Ports:
- clk  in  1  clock
- rst  in  1  synchronous, active-low reset (rst==0 resets on the rising clk edge)
- car_present  in  N_APPR  per-approach sensor; a one-cycle pulse is sufficient
- lights  out  3*N_APPR  one-hot light per approach, slice [3i+2:3i]: GRN=100, YLW=010, RED=001
- owner  out  $clog2(N_APPR)  approach currently holding green or yellow
- phase  out  2  00 GREEN, 01 YELLOW, 10 ALLRED, 11 WALK (optional feature only)
- pending  out  N_APPR  latched demand vector

Behaviour:
- All outputs registered.
- Reset values: phase=GREEN, owner=0, cnt=0, pending=0, lights = approach 0 GRN, all others RED.
- Demand latch: pending[j] is set on any cycle where car_present[j]=1. pending[j] clears on the cycle approach j enters GREEN. Set wins over clear only for the owner, and only while the owner is in YELLOW or ALLRED.
- cnt resets to 0 on every phase entry and increments each cycle. In GREEN it saturates at T_MAX_GRN-1.
- "other" = pending with the owner bit masked.
- GREEN -> YELLOW at the edge where other!=0 and cnt>=T_MIN_GRN-1; T_MAX_GRN bounds this wait.
  - If other==0, stay GREEN indefinitely, even at T_MAX_GRN.
  - Owner's own pending bit never causes a transition.
- YELLOW -> ALLRED at the edge where cnt==T_YLW-1. The owner shows YLW; all others show RED.
- ALLRED -> GREEN at the edge where cnt==T_ALLRED-1. All approaches show RED.
  - New owner = first j with pending[j]=1, searching owner+1, owner+2, ... with modulo wrap.
  - If the search finds nothing (demand withdrawn mid-yellow cannot happen because demand is latched; only possible via reset), new owner = 0.
- Never two non-RED approaches in the same cycle. A YLW is always followed by T_ALLRED all-red cycles.
- Simultaneous requests resolve strictly round-robin from owner+1.
- Reset asserted mid-phase returns to the reset state on that edge; the timer is discarded.
- Sensor input held high on the owner has no effect.

Optional Feature:
- Macro: SCHED_PED_EN.
- When defined:
  - Extra ports ped_req (in, 1) and walk (out, 1).
  - ped_req latches ped_pending.
  - ped_pending counts as "other" demand in GREEN.
  - At ALLRED exit with ped_pending=1, enter WALK (phase=11): walk=1, all lights RED, for T_WALK cycles. Add parameter T_WALK, default 3.
  - WALK then performs the normal round-robin green selection. ped_pending clears on WALK entry.
  - walk resets to 0.
- When undefined: no ped ports, no WALK state, phase never equals 11.

Decomposition:
- Shared package holds:
  - light encodings GRN, YLW, RED
  - phase encodings PH_GREEN, PH_YELLOW, PH_ALLRED, PH_WALK
- One natural sub-module, rr_next_picker: combinational, takes owner and pending, returns next index plus a found flag. Unit-testable in isolation.

Test Plan:
- Reset, no cars -> approach 0 GRN and others RED for 50 cycles; phase=00, owner=0.
- Pulse car_present=0100 one cycle at cycle 1 -> approach 0 GRN cycles 0–3, YLW cycles 4–5, all RED cycle 6, approach 2 GRN from cycle 7, pending=0000 at cycle 7.
- Hold car_present=1110 from reset -> grants in order 1,2,3, each green exactly T_MIN_GRN=4 cycles with 3-cycle yellow/all-red gaps between; never two non-RED lights.
- Approach 2 green, car_present[2] held high, no other demand for 20 cycles -> stays GRN; pulse car_present[0] -> YLW exactly 2 cycles later.
- rst=0 for one edge during YELLOW of approach 1 -> next cycle approach 0 GRN, pending=0, cnt=0.
- With SCHED_PED_EN, pulse ped_req during approach 0 green -> after yellow and all-red, walk=1 with all RED for 3 cycles, then approach 0 GRN again; walk=0 otherwise.
